// File: rtl/restoring_divider_16.sv
// Radix-2 restoring divider: one quotient bit per clock.
// Ports: clk, rst, start/busy/done, dividend, divisor,
// quotient, remainder, div_by_zero.
// Option: RESTORING_DIVIDER_SIGNED_EN selects two's complement operands.
module restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dv_q, dv_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;
  logic             accept;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  // Trial subtract as an add of the inverted divisor with carry-in 1;
  // a set top bit means the subtraction borrowed.
  always_comb begin
    p_sh  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff  = p_sh + {1'b1, ~dv_q} + (WIDTH+1)'(1);
    p_nxt = diff[WIDTH] ? p_sh : diff;
    q_nxt = {q_q[WIDTH-2:0], ~diff[WIDTH]};
  end

`ifdef RESTORING_DIVIDER_SIGNED_EN
  always_comb begin
    mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b = divisor[WIDTH-1] ? -divisor : divisor;
    fin_q = qneg_q ? -q_nxt : q_nxt;
    fin_r = rneg_q ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
  end
`else
  always_comb begin
    mag_a = dividend;
    mag_b = divisor;
    fin_q = q_nxt;
    fin_r = p_nxt[WIDTH-1:0];
  end
`endif

  assign accept = start && !busy_q && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dv_d    = dv_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_RUN: begin
        p_d   = p_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = fin_q;
          rem_d   = fin_r;
          dbz_d   = 1'b0;
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          p_d   = '0;
          cnt_d = '0;
          q_d   = mag_a;
          dv_d  = mag_b;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // No iterations needed: finish on the accept edge.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_16.sv
// Directed bench for restoring_divider_16.
// Hand-computed vectors; one summary line at the end.
module tb_restoring_divider_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  restoring_divider_16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until done.
  task automatic run_div(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input int lat,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez);
    int n;
    int bc;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n  = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, bc, lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, div_by_zero, ez);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);

    run_div("d100_7", 16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0);
    tick();
    chk("done_pulse", done, 0);
    chk("hold_q", quotient, 16'd14);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    run_div("sn7_2", 16'hFFF9, 16'd2, 16, 16'hFFFD, 16'hFFFF, 1'b0);
    run_div("s7_n2", 16'd7, 16'hFFFE, 16, 16'hFFFD, 16'd1, 1'b0);
    run_div("smin", 16'h8000, 16'hFFFF, 16, 16'h8000, 16'd0, 1'b0);
`else
    run_div("ffff_1", 16'hFFFF, 16'd1, 16, 16'hFFFF, 16'd0, 1'b0);
    run_div("d3_10", 16'd3, 16'd10, 16, 16'd0, 16'd3, 1'b0);
    run_div("ffff_ff", 16'hFFFF, 16'hFFFF, 16, 16'd1, 16'd0, 1'b0);
`endif

    run_div("dz5", 16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 1'b1);
    run_div("d9_3", 16'd9, 16'd3, 16, 16'd3, 16'd0, 1'b0);

    // Second start with new operands mid-run must be ignored.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) begin
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("ign_lat", n, 16);
    chk("ign_q", quotient, 16'd14);
    chk("ign_r", remainder, 16'd2);
    tick();

    // start held high: back-to-back accept straight out of DONE.
    @(negedge clk);
    dividend = 16'd20;
    divisor  = 16'd6;
    start    = 1'b1;
    tick();
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b1_lat", n, 16);
    chk("b2b1_q", quotient, 16'd3);
    chk("b2b1_r", remainder, 16'd2);
    dividend = 16'd40;
    tick();
    start = 1'b0;
    chk("b2b2_busy", busy, 1);
    chk("b2b2_done", done, 0);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b2_lat", n, 16);
    chk("b2b2_q", quotient, 16'd6);
    chk("b2b2_r", remainder, 16'd4);
    tick();

    // Reset in the middle of a run.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_z", div_by_zero, 0);

    // start coincident with reset is dropped.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_idle", busy, 0);

    run_div("d1000_3", 16'd1000, 16'd3, 16, 16'd333, 16'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/restoring_divider_16.md
Name: restoring_divider_16

Overview:
- Sequential radix-2 restoring divider: unsigned 16-bit dividend / divisor -> 16-bit quotient and remainder.
- One quotient bit is retired per clock.
- It is the inverse datapath companion to the adder/multiplier blocks. Its trial subtract is a WIDTH+1-bit add of the inverted divisor with carry-in 1, matching the ripple-adder structure.
- Start/busy/done handshake toward a host controller or testbench.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  numerator; captured on accepted start
- divisor  input  WIDTH  denominator; captured on accepted start
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result; held until next completion
- remainder  output  WIDTH  result; held until next completion
- div_by_zero  output  1  captured divisor was 0; held with results

Behaviour:
- Clock and reset: single clock domain `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0, internal registers=0.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: single cycle; done=1, busy=0.
- Accept: start=1 with busy=0, in state IDLE or DONE, at edge E0.
  - Latch the operands.
  - Clear partial remainder P (WIDTH+1 bits) and counter.
  - If divisor!=0: go to RUN, busy=1.
  - If divisor==0: go to DONE at E0 (no RUN).
- RUN, each edge:
  - P' = {P[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
  - D = P' + ~{1'b0,divisor} + 1.
  - If D[WIDTH]==0 (no borrow): P=D and Q[0]=1. Else P=P' and Q[0]=0.
  - Counter increments.
- RUN exit: on the WIDTH-th iteration edge (E0+WIDTH), go to DONE.
  - quotient=Q, remainder=P[WIDTH-1:0], div_by_zero=0.
  - done=1, busy=0.
- Latency: done is visible the cycle after edge E0+WIDTH, i.e. 16 cycles for WIDTH=16. Divide-by-zero: done the cycle after E0.
- Divide by zero results: quotient = all ones, remainder = dividend, div_by_zero=1.
- DONE: returns to IDLE next edge unless start=1, in which case the new request is accepted (back-to-back; no idle bubble required).
- start while busy=1 is ignored. Operand changes while busy have no effect.
- Outputs quotient, remainder and div_by_zero change only on completion or reset.
- Reset mid-RUN: all outputs and state return to reset values on that edge. A start coincident with rst is ignored.
- Remainder is always < divisor when divisor != 0. Invariant: quotient*divisor + remainder == dividend.

Optional Feature:
- Macro: RESTORING_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - On accept, magnitudes are captured and the signs registered.
  - On completion, the quotient is negated if the signs differ, and the remainder takes the dividend's sign (truncation toward zero).
  - Most-negative / -1: quotient = 0x8000 (wrap), remainder = 0, no flag.
  - Divide by zero: quotient all ones, remainder = dividend.
  - Latency unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Test Plan:
- Basic divide: dividend=100, divisor=7, start pulse -> done exactly 16 cycles after accept edge; quotient=14, remainder=2, div_by_zero=0; busy=1 for cycles 1-16 only.
- Boundary values:
  - 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
  - 3/10 -> quotient=0, remainder=3.
  - 0xFFFF/0xFFFF -> quotient=1, remainder=0.
- Divide by zero: 5/0 -> done the cycle after accept; quotient=0xFFFF, remainder=5, div_by_zero=1. A following 9/3 clears the flag -> quotient=3, remainder=0.
- Handshake:
  - start re-asserted with 50/5 at cycle 4 of a running 100/7 -> ignored; result 14 r2.
  - start held high in DONE -> back-to-back accept, second done 16 cycles later.
- Reset mid-operation: rst at cycle 8 of 1000/3 -> next cycle busy=0, done=0, quotient=0, remainder=0. A fresh 1000/3 -> quotient=333, remainder=1.
- Signed mode (RESTORING_DIVIDER_SIGNED_EN):
  - -7/2 -> quotient=0xFFFD, remainder=0xFFFF.
  - 7/-2 -> quotient=0xFFFD, remainder=1.
  - 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
